sfr_access_ctrl: RTL
====================

SFR_ACCESS_CTRL -- requirements
Module: sfr_access_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, SFR data width.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  / req_ready  out  1  request handshake; transfer when both are high at a rising edge.
REQ-006 req_op  in  3  000 BYTE_RD, 001 BYTE_WR, 010 BIT_RD, 011 BIT_WR, 100 BIT_CPL; others illegal.
REQ-007 req_addr  in  8  byte address (byte ops) or 8051 bit address (bit ops); legal range 0x80-0xFF.
REQ-008 req_wdata  in  WIDTH  byte write data; req_wbit  in  1  bit write data.
REQ-009 rsp_valid  out  1  / rsp_ready  in  1  response handshake.
REQ-010 rsp_data  out  WIDTH, rsp_bit  out  1, rsp_err  out  1  read results and error flag.
REQ-011 sfr_addr  out  8, sfr_en  out  1, sfr_oe  out  1, sfr_Bb  out  1 (1 = byte, 0 = bit), sfr_position  out  WIDTH one-hot, sfr_din  out  WIDTH, sfr_bin  out  1  SFR bus drive.
REQ-012 sfr_dout  in  WIDTH, sfr_bout  in  1  SFR read return; the SFRs sample and update on the falling clock edge.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS, CPL_WR, RESP.
REQ-014 IDLE: req_ready=1. On transfer: a legal op and address go to ACCESS; an illegal op or req_addr<0x80 goes directly to RESP with rsp_err=1 and no bus activity.
REQ-015 Bit ops: sfr_addr = {req_addr[7:3],3'b000}; sfr_position = one-hot of req_addr[2:0]; sfr_Bb=0. Byte ops: sfr_addr = req_addr; sfr_position=0; sfr_Bb=1.
REQ-016 ACCESS lasts exactly one cycle. Read ops drive sfr_oe=1, sfr_en=0. Write ops drive sfr_en=1, sfr_oe=0, with sfr_din/sfr_bin taken from the request.
REQ-017 At the ACCESS-ending rising edge, reads capture sfr_dout into rsp_data and sfr_bout into rsp_bit. rsp_data/rsp_bit SHALL be 0 for write ops.
REQ-018 BIT_CPL: ACCESS performs a bit read and then goes to CPL_WR, which drives a one-cycle bit write with sfr_bin = ~captured bit; rsp_bit returns the pre-complement value.
REQ-019 Latency: rsp_valid rises 2 cycles after acceptance (3 for BIT_CPL, 1 for error).
REQ-020 RESP: rsp_valid=1 with outputs held stable until rsp_ready; then go to IDLE. req_ready=0 in every non-IDLE state. There is no back-to-back overlap.
REQ-021 The bus idle value, driven in IDLE and RESP, SHALL be: en=0, oe=0, Bb=1, position=0, din=0, bin=0, addr=0x00.
REQ-022 sfr_en and sfr_oe SHALL never be high simultaneously.

Reset
REQ-023 Reset SHALL force IDLE; all outputs take the bus idle value; rsp_valid=0, rsp_data=0, rsp_bit=0, rsp_err=0; req_ready=1 after the reset edge.
REQ-024 Reset in ACCESS, CPL_WR or RESP SHALL abort the operation: no response is issued, and the bus is idle from the next cycle.

Configuration
REQ-025 Macro SFR_BIT_CPL_EN: when defined, BIT_CPL and the CPL_WR state are implemented; when undefined, op 100 is illegal (rsp_err=1) and the CPL_WR state is absent.

Structure
REQ-026 A shared package sfr_bus_pkg SHALL hold the op encodings, the FSM state enum, SFR_BASE=8'h80 and the bus idle constants.
REQ-027 The sub-module sfr_bitpos_dec (3-bit index to WIDTH one-hot) SHALL be instantiated once.

Verification
REQ-028 BYTE_WR addr 0xA0, data 0x5A -> one cycle with sfr_en=1, Bb=1, sfr_din=0x5A, addr 0xA0; rsp_valid 2 cycles after acceptance, rsp_err=0.
REQ-029 BIT_RD addr 0xD7 with SFR holding 0x80 -> sfr_addr=0xD0, position=0x80, oe=1; rsp_bit=1.
REQ-030 BIT_CPL addr 0x8B with SFR holding 0x08 (macro on) -> read, then write bin=0; SFR becomes 0x00; rsp_bit=1 at 3 cycles. With the macro off -> rsp_err=1 at 1 cycle and no bus activity.
REQ-031 BYTE_RD addr 0x40 -> rsp_err=1, sfr_en/sfr_oe stay 0 throughout.
REQ-032 Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and req_ready=0 are held stable; release returns to IDLE next cycle.
REQ-033 Assert reset during ACCESS of a BYTE_WR -> no rsp_valid; the bus is idle next cycle; req_ready=1.

Source files
------------

// File: rtl/sfr_bus_pkg.sv
// Shared encodings for the SFR access controller.
// Macro SFR_BIT_CPL_EN enables the BIT_CPL op.
package sfr_bus_pkg;

  typedef enum logic [2:0] {
    OP_BYTE_RD = 3'b000,
    OP_BYTE_WR = 3'b001,
    OP_BIT_RD  = 3'b010,
    OP_BIT_WR  = 3'b011,
    OP_BIT_CPL = 3'b100
  } sfr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_CPL_WR = 2'd2,
    ST_RESP   = 2'd3
  } sfr_state_e;

  localparam logic [7:0] SFR_BASE = 8'h80;

  localparam logic [7:0] BUS_IDLE_ADDR = 8'h00;
  localparam logic       BUS_IDLE_EN   = 1'b0;
  localparam logic       BUS_IDLE_OE   = 1'b0;
  localparam logic       BUS_IDLE_BB   = 1'b1;
  localparam logic       BUS_IDLE_BIN  = 1'b0;

  function automatic logic op_is_legal(
    input logic [2:0] op
  );
    logic ok;
    ok = 1'b0;
    case (op)
      OP_BYTE_RD,
      OP_BYTE_WR,
      OP_BIT_RD,
      OP_BIT_WR:  ok = 1'b1;
`ifdef SFR_BIT_CPL_EN
      OP_BIT_CPL: ok = 1'b1;
`endif
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // BIT_CPL starts with a read of the target bit.
  function automatic logic op_is_read(
    input logic [2:0] op
  );
    return (op == OP_BYTE_RD) ||
           (op == OP_BIT_RD)  ||
           (op == OP_BIT_CPL);
  endfunction

  function automatic logic op_is_bit(
    input logic [2:0] op
  );
    return (op == OP_BIT_RD) ||
           (op == OP_BIT_WR) ||
           (op == OP_BIT_CPL);
  endfunction

endpackage

// File: rtl/sfr_bitpos_dec.sv
// 3-bit bit index to one-hot lane select.
// Lanes beyond WIDTH are never selected.
module sfr_bitpos_dec #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       idx,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      onehot[i] = (int'(idx) == i);
    end
  end

endmodule

// File: rtl/sfr_access_ctrl.sv
// Request/response front end driving the 8051 SFR bus.
// Macro SFR_BIT_CPL_EN adds BIT_CPL and the CPL_WR state.
module sfr_access_ctrl
  import sfr_bus_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [7:0]       req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic             req_wbit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_bit,
  output logic             rsp_err,
  output logic [7:0]       sfr_addr,
  output logic             sfr_en,
  output logic             sfr_oe,
  output logic             sfr_Bb,
  output logic [WIDTH-1:0] sfr_position,
  output logic [WIDTH-1:0] sfr_din,
  output logic             sfr_bin,
  input  logic [WIDTH-1:0] sfr_dout,
  input  logic             sfr_bout
);

  sfr_state_e       state_q;
  logic [2:0]       op_q;
  logic [7:0]       addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             wbit_q;

  logic             req_ok;
  logic             rd_op;
  logic             bit_op;
  logic [7:0]       bit_base;
  logic [WIDTH-1:0] pos;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);

  assign req_ok = op_is_legal(req_op) &&
                  (req_addr >= SFR_BASE);

  assign rd_op    = op_is_read(op_q);
  assign bit_op   = op_is_bit(op_q);
  assign bit_base = {addr_q[7:3], 3'b000};

  sfr_bitpos_dec #(
    .WIDTH (WIDTH)
  ) u_bitpos (
    .idx    (addr_q[2:0]),
    .onehot (pos)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wbit_q   <= 1'b0;
      rsp_data <= '0;
      rsp_bit  <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wbit_q   <= req_wbit;
            rsp_data <= '0;
            rsp_bit  <= 1'b0;
            rsp_err  <= ~req_ok;
            state_q  <= req_ok ? ST_ACCESS
                               : ST_RESP;
          end
        end
        ST_ACCESS: begin
          if (rd_op) begin
            rsp_data <= sfr_dout;
            rsp_bit  <= sfr_bout;
          end
`ifdef SFR_BIT_CPL_EN
          if (op_q == OP_BIT_CPL) begin
            state_q <= ST_CPL_WR;
          end else begin
            state_q <= ST_RESP;
          end
`else
          state_q <= ST_RESP;
`endif
        end
`ifdef SFR_BIT_CPL_EN
        ST_CPL_WR: begin
          state_q <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outside the active cycles the bus rests at its idle value.
  always_comb begin
    sfr_addr     = BUS_IDLE_ADDR;
    sfr_en       = BUS_IDLE_EN;
    sfr_oe       = BUS_IDLE_OE;
    sfr_Bb       = BUS_IDLE_BB;
    sfr_position = '0;
    sfr_din      = '0;
    sfr_bin      = BUS_IDLE_BIN;
    case (state_q)
      ST_ACCESS: begin
        sfr_addr     = bit_op ? bit_base : addr_q;
        sfr_Bb       = ~bit_op;
        sfr_position = bit_op ? pos : '0;
        sfr_oe       = rd_op;
        sfr_en       = ~rd_op;
        if (!rd_op && !bit_op) begin
          sfr_din = wdata_q;
        end
        sfr_bin = ~rd_op & bit_op & wbit_q;
      end
`ifdef SFR_BIT_CPL_EN
      // Write back the inverse of the bit read in ACCESS.
      ST_CPL_WR: begin
        sfr_addr     = bit_base;
        sfr_Bb       = 1'b0;
        sfr_position = pos;
        sfr_en       = 1'b1;
        sfr_bin      = ~rsp_bit;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule
